// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads 32-bit words from synchronous instruction memory
// and issues long words once, or short pairs upper half first, to instr_decoder.
module instr_fetch #(
  parameter int                WIDTH      = 32,
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              jump_half,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  input  logic [WIDTH-1:0]  imem_data,
  output logic              en,
  output logic [WIDTH-1:0]  long_instr,
  output logic              instr_choose,
  output logic [ADDR_W-1:0] pc_out
);

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    HI,
    LO
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [WIDTH-1:0]  word_buf;
  logic              start_lo;
  logic              redirect;
  logic              issue_hi;
  logic              issue_lo;

  assign pc_inc   = pc + ADDR_W'(1);
  assign redirect = jump_valid && (state != BOOT);

  // A redirect beats stall and any issue; memory is only read from REQ or a firing LO.
  always_comb begin
    next_state = state;
    imem_rd    = 1'b0;
    imem_addr  = pc;
    issue_hi   = 1'b0;
    issue_lo   = 1'b0;
    if (redirect) begin
      next_state = REQ;
    end else begin
      case (state)
        BOOT: next_state = REQ;
        REQ: begin
          imem_rd    = 1'b1;
          next_state = WAIT;
        end
        WAIT: begin
          if (start_lo && !imem_data[WIDTH-1]) next_state = LO;
          else                                 next_state = HI;
        end
        HI: begin
          if (!stall) begin
            issue_hi   = 1'b1;
            next_state = word_buf[WIDTH-1] ? REQ : LO;
          end
        end
        LO: begin
          if (!stall) begin
            issue_lo   = 1'b1;
            imem_rd    = 1'b1;
            imem_addr  = pc_inc;
            next_state = WAIT;
          end
        end
        default: next_state = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_ADDR;
      word_buf <= '0;
      start_lo <= 1'b0;
    end else begin
      state <= next_state;
      if (redirect) begin
        pc       <= jump_addr;
        start_lo <= jump_half;
      end else begin
        if (state == WAIT) begin
          word_buf <= imem_data;
          start_lo <= 1'b0;
        end
        if ((issue_hi && word_buf[WIDTH-1]) || issue_lo) pc <= pc_inc;
      end
    end
  end

  // Decoder-facing outputs hold their last values between issues; en pulses per issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en           <= 1'b0;
      long_instr   <= '0;
      instr_choose <= 1'b0;
      pc_out       <= '0;
    end else begin
      en <= issue_hi || issue_lo;
      if (issue_hi || issue_lo) begin
        long_instr   <= word_buf;
        instr_choose <= issue_lo;
        pc_out       <= pc;
      end
    end
  end

endmodule
